// File: rtl/csr_avmm_responder.sv
// AFU CSR responder: 64-bit Avalon-MM slave serving local AFU registers and
// bridging a MAC window onto a 32-bit CSR master with per-half timeouts.
module csr_avmm_responder #(
    parameter logic [63:0] DFH_VALUE = 64'h1000_0000_0000_1000,
    parameter logic [63:0] AFU_ID_L  = 64'h0,
    parameter logic [63:0] AFU_ID_H  = 64'h0,
    parameter int unsigned TIMEOUT   = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [17:0] avmm_address,
    input  logic        avmm_read,
    input  logic        avmm_write,
    input  logic [63:0] avmm_writedata,
    input  logic [7:0]  avmm_byteenable,
    output logic        avmm_waitrequest,
    output logic [63:0] avmm_readdata,
    output logic        avmm_readdatavalid,
    output logic [15:0] mac_csr_address,
    output logic        mac_csr_read,
    output logic        mac_csr_write,
    output logic [31:0] mac_csr_writedata,
    input  logic        mac_csr_waitrequest,
    input  logic [31:0] mac_csr_readdata,
    input  logic        mac_csr_readdatavalid
);

    // Handshake: upstream command is taken on a clock edge where
    // (read|write) & !waitrequest; downstream likewise on (read|write) &
    // !mac_csr_waitrequest. Read data returns on a one-cycle *readdatavalid.

    typedef enum logic [2:0] {
        IDLE, LOCAL_RSP, LO_REQ, LO_DATA, HI_REQ, HI_DATA, RSP
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

    state_t      state, state_nxt;
    logic        accept, is_mac, lo_en, hi_en, local_wr;
    logic        in_req, in_data, is_hi_half, tmo_hit;
    logic        half_done, half_tmo, half_end;
    logic [8:0]  offset;
    logic [63:0] local_rdata;

    logic        op_rd_q, hi_pend_q;
    logic [12:0] waddr_q;
    logic [63:0] wdata_q, rdata_q, scratch_q;
    logic [15:0] tmo_cnt_q;
    logic [31:0] timeout_count_q, mac_txn_count_q;

    logic        unused_addr_bits;
    assign unused_addr_bits = ^avmm_address[2:0];

    assign avmm_waitrequest   = reset | (state != IDLE);
    assign accept             = (avmm_read | avmm_write) & ~avmm_waitrequest;
    assign is_mac             = (avmm_address[17:16] == 2'b01);
    assign lo_en              = |avmm_byteenable[3:0];
    assign hi_en              = |avmm_byteenable[7:4];
    assign offset             = avmm_address[11:3];
    assign local_wr           = accept & ~avmm_read & ~is_mac;

    assign in_req     = (state == LO_REQ) || (state == HI_REQ);
    assign in_data    = (state == LO_DATA) || (state == HI_DATA);
    assign is_hi_half = (state == HI_REQ) || (state == HI_DATA);
    // >= rather than == so a read accepted on its last allowed cycle still
    // aborts if its data never shows up in *_DATA.
    assign tmo_hit    = (tmo_cnt_q >= TMO_LAST);

    assign avmm_readdata      = rdata_q;
    assign avmm_readdatavalid = (state == LOCAL_RSP) || (state == RSP);
    assign mac_csr_read       = in_req & op_rd_q;
    assign mac_csr_write      = in_req & ~op_rd_q;
    assign mac_csr_address    = in_req ? {2'b00, waddr_q, is_hi_half} : 16'd0;
    assign mac_csr_writedata  = !in_req    ? 32'd0 :
                                is_hi_half ? wdata_q[63:32] : wdata_q[31:0];

    always_comb begin
        local_rdata = 64'd0;
        case (offset)
            9'd0:    local_rdata = DFH_VALUE;
            9'd1:    local_rdata = AFU_ID_L;
            9'd2:    local_rdata = AFU_ID_H;
            9'd3:    local_rdata = scratch_q;
            9'd4:    local_rdata = {mac_txn_count_q, timeout_count_q};
            default: local_rdata = 64'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        half_done = 1'b0;
        half_tmo  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_mac) begin
                        if (lo_en)          state_nxt = LO_REQ;
                        else if (hi_en)     state_nxt = HI_REQ;
                        else if (avmm_read) state_nxt = RSP;
                        else                state_nxt = IDLE;
                    end else if (avmm_read) begin
                        state_nxt = LOCAL_RSP;
                    end
                end
            end
            LOCAL_RSP, RSP: state_nxt = IDLE;
            LO_REQ, HI_REQ: begin
                if (!mac_csr_waitrequest) begin
                    if (op_rd_q) state_nxt = (state == LO_REQ) ? LO_DATA : HI_DATA;
                    else         half_done = 1'b1;
                end else if (tmo_hit) begin
                    half_tmo = 1'b1;
                end
            end
            LO_DATA, HI_DATA: begin
                if (mac_csr_readdatavalid) half_done = 1'b1;
                else if (tmo_hit)          half_tmo  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase

        half_end = half_done | half_tmo;
        if (half_end) begin
            if (!is_hi_half && hi_pend_q) state_nxt = HI_REQ;
            else if (op_rd_q)             state_nxt = RSP;
            else                          state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_rd_q         <= 1'b0;
            hi_pend_q       <= 1'b0;
            waddr_q         <= 13'd0;
            wdata_q         <= 64'd0;
            rdata_q         <= 64'd0;
            scratch_q       <= 64'd0;
            tmo_cnt_q       <= 16'd0;
            timeout_count_q <= 32'd0;
            mac_txn_count_q <= 32'd0;
        end else begin
            if (accept) begin
                op_rd_q   <= avmm_read;
                hi_pend_q <= hi_en;
                waddr_q   <= avmm_address[15:3];
                wdata_q   <= avmm_writedata;
                if (avmm_read) rdata_q <= is_mac ? 64'd0 : local_rdata;
            end

            if (local_wr && offset == 9'd3) begin
                for (int i = 0; i < 8; i++) begin
                    if (avmm_byteenable[i]) scratch_q[8*i +: 8] <= avmm_writedata[8*i +: 8];
                end
            end

            if ((state_nxt == LO_REQ || state_nxt == HI_REQ) && state_nxt != state) begin
                tmo_cnt_q <= 16'd0;
            end else if ((in_req || in_data) && tmo_cnt_q != 16'hFFFF) begin
                tmo_cnt_q <= tmo_cnt_q + 16'd1;
            end

            if (half_done && in_data) begin
                if (is_hi_half) rdata_q[63:32] <= mac_csr_readdata;
                else            rdata_q[31:0]  <= mac_csr_readdata;
            end
            if (half_tmo && op_rd_q) begin
                if (is_hi_half) rdata_q[63:32] <= 32'hDEAD_BEEF;
                else            rdata_q[31:0]  <= 32'hDEAD_BEEF;
            end

            // STATUS writes happen only in IDLE, so they never race an increment.
            if (local_wr && offset == 9'd4) begin
                timeout_count_q <= 32'd0;
                mac_txn_count_q <= 32'd0;
            end else begin
                if (half_tmo && timeout_count_q != CNT_MAX)
                    timeout_count_q <= timeout_count_q + 32'd1;
                if (half_end && mac_txn_count_q != CNT_MAX)
                    mac_txn_count_q <= mac_txn_count_q + 32'd1;
            end
        end
    end

endmodule

// File: doc/csr_avmm_responder.md
Name: csr_avmm_responder

Overview:
- 64-bit Avalon-MM slave that answers the AFU MMIO bridge's master port.
- Serves local AFU registers: DFH, AFU ID, scratch and status counters.
- Forwards a MAC window to the 32-bit MAC CSR master port. A 64-bit access becomes one or two 32-bit downstream transactions.
- Downstream accesses are bounded by a timeout counter, so a hung MAC can never stall MMIO.

Parameters:
- DFH_VALUE, 64'h1000_0000_0000_1000, value returned at offset 0x00
- AFU_ID_L, 64'h0, value returned at offset 0x08
- AFU_ID_H, 64'h0, value returned at offset 0x10
- TIMEOUT, 256, cycles allowed per downstream transaction before abort (range 2..65535)

Ports:
- clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high
- avmm_address  in  18  byte address; bits [2:0] ignored
- avmm_read  in  1  read request
- avmm_write  in  1  write request
- avmm_writedata  in  64  write data
- avmm_byteenable  in  8  byte enables
- avmm_waitrequest  out  1  high = command not accepted
- avmm_readdata  out  64  read data
- avmm_readdatavalid  out  1  one-cycle read response strobe
- mac_csr_address  out  16  32-bit word address
- mac_csr_read  out  1  downstream read
- mac_csr_write  out  1  downstream write
- mac_csr_writedata  out  32  downstream write data
- mac_csr_waitrequest  in  1  downstream stall
- mac_csr_readdata  in  32  downstream read data
- mac_csr_readdatavalid  in  1  downstream read strobe

Behaviour:
- Reset values:
  - avmm_waitrequest=1 during reset, 0 in the first cycle after reset deasserts.
  - All other outputs 0; scratch 0; counters 0; FSM IDLE.
  - Reset mid-transaction aborts it with no upstream response.
- Acceptance: the command is accepted when (read|write) & !avmm_waitrequest. avmm_waitrequest=1 whenever FSM != IDLE.
- Decode:
  - address[17:16]==2'b01 → MAC window.
  - Otherwise local, using offset address[11:3].
- Local registers (read latency 1: readdatavalid the cycle after acceptance):
  - 0x00 DFH_VALUE, RO.
  - 0x08 AFU_ID_L, RO.
  - 0x10 AFU_ID_H, RO.
  - 0x18 SCRATCH, RW; per-byte writes honor byteenable.
  - 0x20 STATUS, RO: [31:0] timeout_count, [63:32] mac_txn_count. Any write clears both.
  - All other offsets read 0; writes to them are ignored.
- Counters saturate at 32'hFFFF_FFFF.
- MAC window:
  - lo = |byteenable[3:0]; hi = |byteenable[7:4].
  - Low address {address[15:3],1'b0}, data writedata[31:0].
  - High address {address[15:3],1'b1}, data writedata[63:32].
  - Low is issued before high.
  - byteenable==0 read → readdatavalid with 0 one cycle later; byteenable==0 write → dropped.
- FSM states: IDLE, LOCAL_RSP, LO_REQ, LO_DATA, HI_REQ, HI_DATA, RSP.
  - IDLE→LOCAL_RSP (local read), or →LO_REQ/HI_REQ (MAC, per lo/hi). Local write completes in IDLE.
  - *_REQ: hold read/write, address and data stable until !mac_csr_waitrequest.
  - Write: acceptance ends the half.
  - Read: go to *_DATA and wait for mac_csr_readdatavalid, which may arrive in the cycle after acceptance or later.
  - After LO, go to HI_REQ if hi, else RSP (reads) or IDLE (writes).
  - RSP: one-cycle readdatavalid; an unaccessed half returns 0. Then IDLE.
- Timeout:
  - One counter per half; it clears on entering *_REQ and counts cycles in *_REQ plus *_DATA.
  - At count==TIMEOUT-1 without completion: drop mac_csr_read/write and substitute 32'hDEADBEEF for that half's read data.
  - Then increment timeout_count and proceed as if the half completed.
- mac_txn_count increments once per downstream half completed, including timeouts.
- A mac_csr_readdatavalid arriving outside *_DATA is ignored.
- Upstream read and write asserted together: treat as a read; write ignored.

Test Plan:
- Reset, then read 0x00, 0x08, 0x18 → readdatavalid 1 cycle after each acceptance; data DFH_VALUE, AFU_ID_L, 0; waitrequest 1 during reset, 0 the cycle after.
- Write 0x18 data 64'h1122334455667788, be=8'h0F, then read 0x18 → 64'h0000000055667788.
- MAC write addr 0x10010, be=8'hFF, data 64'hAAAA_BBBB_CCCC_DDDD, with mac_csr_waitrequest high 3 cycles → two writes: addr 0x0004 data CCCCDDDD, then 0x0005 data AAAABBBB; mac_txn_count=2.
- MAC read addr 0x10008, be=8'hF0, downstream returns 32'h12345678 after 5 cycles → only addr 0x0003 read; avmm_readdata 64'h12345678_00000000; upstream waitrequest high throughout.
- MAC read be=8'hFF, downstream never responds, TIMEOUT=16 → each half aborts after 16 cycles; readdata 64'hDEADBEEF_DEADBEEF; STATUS read → 64'h00000002_00000002; write STATUS → 0.
- Assert reset in LO_DATA, then a stray mac_csr_readdatavalid arrives → no upstream readdatavalid; FSM IDLE; next local read works normally.
